// File: rtl/sd_capture_ctrl_if.sv
// Readout port of the sigma-delta capture sequencer.
// The master drives the FIFO head word and its valid flag; the slave returns ready.
// A word transfers on any clock edge where out_valid and out_ready are both high.
interface sd_capture_ctrl_if #(
    parameter int PCM_W = 24
);
    logic [PCM_W-1:0] pcm_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output pcm_out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  pcm_out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sd_capture_ctrl.sv
// Capture sequencer wrapped around the sigma-delta decimator.
// It gates the modulator bitstream into the decimator and clears the filter before each run.
// It then discards cfg_settle PCM words, keeps cfg_count words and buffers them in a
// first-word-fall-through FIFO behind a valid/ready readout port.
// Optional feature macro: SD_CAP_TIMEOUT_EN. It adds a PCM-word watchdog and the
// err_timeout output.
module sd_capture_ctrl #(
    parameter int PCM_W       = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 16,
    parameter int FLUSH_CYC   = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        cfg_settle,
    input  logic [CNT_W-1:0]        cfg_count,
    input  logic                    mod_bit,
    input  logic                    mod_valid,
    output logic                    dec_bit,
    output logic                    dec_valid,
    output logic                    dec_clr,
    input  logic signed [PCM_W-1:0] pcm_in,
    input  logic                    pcm_in_valid,
    sd_capture_ctrl_if.master       rd,
    output logic                    busy,
    output logic                    done,
`ifdef SD_CAP_TIMEOUT_EN
    output logic                    err_timeout,
`endif
    output logic                    overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FLUSH_CYC + 1);

    // Catch unusable parameter sets at elaboration time.
    if (TIMEOUT_CYC < 2 || FLUSH_CYC < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("sd_capture_ctrl: bad parameters");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [FW-1:0]    flush_cnt_q;
    logic [CNT_W-1:0] settle_q;
    logic [CNT_W-1:0] keep_q;
    logic             dec_bit_q;
    logic             dec_valid_q;
    logic             dec_clr_q;
    logic             done_q;
    logic             overflow_q;

    // Capture FIFO storage and pointers (extra MSB distinguishes full from empty).
    logic [PCM_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    logic fifo_empty, fifo_full;
    logic pop, push_req, push, drop, kill;
    logic timeout_hit;

`ifdef SD_CAP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_timeout_q;

    // Watchdog fires on the TIMEOUT_CYC-th wordless cycle spent in SETTLE/CAPTURE.
    assign timeout_hit = (state_q == ST_SETTLE || state_q == ST_CAPTURE) && !pcm_in_valid
                         && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Abort and watchdog expiry both cancel the run and empty the FIFO.
    assign kill     = abort | timeout_hit;
    assign pop      = !fifo_empty && rd.out_ready;
    assign push_req = (state_q == ST_CAPTURE) && pcm_in_valid && (keep_q != '0);
    // A simultaneous pop frees the slot, so a push at full still succeeds then.
    assign push     = push_req && (!fifo_full || pop) && !kill;
    assign drop     = push_req && fifo_full && !pop;

    assign rd.out_valid = !fifo_empty;
    assign rd.pcm_out   = fifo_mem[rd_ptr_q[AW-1:0]];

    assign dec_bit   = dec_bit_q;
    assign dec_valid = dec_valid_q;
    assign dec_clr   = dec_clr_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != ST_IDLE);

    // Next FIFO pointers: cleared on kill, otherwise advanced by push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage write; the array has no reset so it can map to memory.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= pcm_in;
    end

    // Run sequencer with registered decimator controls and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            settle_q    <= '0;
            keep_q      <= '0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef SD_CAP_TIMEOUT_EN
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else if (kill) begin
            // overflow is deliberately left alone so the consumer can still see it.
            state_q     <= ST_IDLE;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_clr_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef SD_CAP_TIMEOUT_EN
            wd_q <= '0;
            if (timeout_hit) err_timeout_q <= 1'b1;
`endif
        end else begin
            done_q      <= 1'b0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            if (drop) overflow_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        settle_q    <= cfg_settle;
                        keep_q      <= cfg_count;
                        overflow_q  <= 1'b0;
                        flush_cnt_q <= FW'(FLUSH_CYC - 1);
                        dec_clr_q   <= 1'b1;
                        state_q     <= ST_FLUSH;
`ifdef SD_CAP_TIMEOUT_EN
                        err_timeout_q <= 1'b0;
`endif
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        // The stream gate opens together with the filter clear dropping.
                        dec_clr_q   <= 1'b0;
                        dec_bit_q   <= mod_bit;
                        dec_valid_q <= mod_valid;
                        state_q     <= (settle_q == '0) ? ST_CAPTURE : ST_SETTLE;
`ifdef SD_CAP_TIMEOUT_EN
                        wd_q <= '0;
`endif
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    dec_bit_q   <= mod_bit;
                    dec_valid_q <= mod_valid;
                    if (pcm_in_valid) begin
                        settle_q <= settle_q - 1'b1;
                        if (settle_q == CNT_W'(1)) state_q <= ST_CAPTURE;
`ifdef SD_CAP_TIMEOUT_EN
                        wd_q <= '0;
`endif
                    end else begin
`ifdef SD_CAP_TIMEOUT_EN
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                ST_CAPTURE: begin
                    if (keep_q == '0) begin
                        state_q <= ST_DRAIN;
                    end else if (pcm_in_valid) begin
                        keep_q <= keep_q - 1'b1;
`ifdef SD_CAP_TIMEOUT_EN
                        wd_q <= '0;
`endif
                        if (keep_q == CNT_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            dec_bit_q   <= mod_bit;
                            dec_valid_q <= mod_valid;
                        end
                    end else begin
                        dec_bit_q   <= mod_bit;
                        dec_valid_q <= mod_valid;
`ifdef SD_CAP_TIMEOUT_EN
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
